// File: rtl/parameter_ram_arbiter.sv
// parameter_ram_arbiter
//   Shares the single write port and single read port of parameter_ram between
//   requester A (host register bus) and requester B (sequencer/loader).
//   Write and read paths each have an independent two-way round-robin arbiter.
//   RAM commands are registered. Read responses are steered back to the issuer
//   by a tag pipeline that is aligned to the RAM read latency.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   {a,b}_w{data,add,mask}_in write payload;  {a,b}_wreq_in / {a,b}_wack_out
//   {a,b}_radd_in             read address;   {a,b}_rreq_in / {a,b}_rack_out
//   {a,b}_rdata_out/_rval_out read response (rval is a one-cycle pulse)
//   ram_*_out / ram_*_in      direct connection to parameter_ram
//   err_out                   sticky: rval arrived without a tag, or tag without rval

// Two-requester round-robin arbiter. r_pri = 0 favours A, 1 favours B.
// Priority only moves when both request, so a lone requester never
// steals the other's turn.
module parameter_ram_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);
  logic r_pri;

  always_comb begin
    o_gnt_a = rst && i_req_a && (!i_req_b || !r_pri);
    o_gnt_b = rst && i_req_b && (!i_req_a ||  r_pri);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_pri <= 1'b0;
    else if (i_req_a && i_req_b) r_pri <= ~r_pri;
  end
endmodule

module parameter_ram_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_wdata_in,
  input  logic [ADDR_W-1:0] a_wadd_in,
  input  logic [DATA_W-1:0] a_wmask_in,
  input  logic              a_wreq_in,
  output logic              a_wack_out,
  input  logic [DATA_W-1:0] b_wdata_in,
  input  logic [ADDR_W-1:0] b_wadd_in,
  input  logic [DATA_W-1:0] b_wmask_in,
  input  logic              b_wreq_in,
  output logic              b_wack_out,
  input  logic [ADDR_W-1:0] a_radd_in,
  input  logic              a_rreq_in,
  output logic              a_rack_out,
  input  logic [ADDR_W-1:0] b_radd_in,
  input  logic              b_rreq_in,
  output logic              b_rack_out,
  output logic [DATA_W-1:0] a_rdata_out,
  output logic              a_rval_out,
  output logic [DATA_W-1:0] b_rdata_out,
  output logic              b_rval_out,
  output logic [DATA_W-1:0] ram_wdata_out,
  output logic [ADDR_W-1:0] ram_wadd_out,
  output logic [DATA_W-1:0] ram_wmask_out,
  output logic              ram_wval_out,
  output logic              ram_wen_out,
  output logic [ADDR_W-1:0] ram_radd_out,
  output logic              ram_ren_out,
  input  logic [DATA_W-1:0] ram_rdata_in,
  input  logic              ram_rval_in,
  output logic              err_out
);
  logic w_wgnt_a, w_wgnt_b, w_rgnt_a, w_rgnt_b;

  parameter_ram_rr_arb u_warb (
    .clk(clk), .rst(rst), .i_req_a(a_wreq_in), .i_req_b(b_wreq_in),
    .o_gnt_a(w_wgnt_a), .o_gnt_b(w_wgnt_b)
  );

  parameter_ram_rr_arb u_rarb (
    .clk(clk), .rst(rst), .i_req_a(a_rreq_in), .i_req_b(b_rreq_in),
    .o_gnt_a(w_rgnt_a), .o_gnt_b(w_rgnt_b)
  );

  assign a_wack_out = w_wgnt_a;
  assign b_wack_out = w_wgnt_b;
  assign a_rack_out = w_rgnt_a;
  assign b_rack_out = w_rgnt_b;

  // ---------------- write issue ----------------
  logic              r_wv;
  logic [DATA_W-1:0] r_wdata, r_wmask;
  logic [ADDR_W-1:0] r_wadd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wv    <= 1'b0;
      r_wdata <= '0;
      r_wadd  <= '0;
      r_wmask <= '0;
    end else begin
      r_wv <= w_wgnt_a | w_wgnt_b;
      // payload registers hold their last value when idle
      if (w_wgnt_a) begin
        r_wdata <= a_wdata_in;
        r_wadd  <= a_wadd_in;
        r_wmask <= a_wmask_in;
      end else if (w_wgnt_b) begin
        r_wdata <= b_wdata_in;
        r_wadd  <= b_wadd_in;
        r_wmask <= b_wmask_in;
      end
    end
  end

  assign ram_wdata_out = r_wdata;
  assign ram_wadd_out  = r_wadd;
  assign ram_wmask_out = r_wmask;
  assign ram_wval_out  = r_wv;
  assign ram_wen_out   = r_wv;

  // ---------------- read issue + tag pipeline ----------------
  // Stage 0 is the issue register itself (it drives ram_ren_out), so stage
  // RD_LATENCY lines up with the cycle the RAM raises rval.
  logic [RD_LATENCY:0] r_vld_pipe;
  logic [RD_LATENCY:0] r_id_pipe;   // 0 = A, 1 = B
  logic [ADDR_W-1:0]   r_radd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
      r_radd     <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[RD_LATENCY-1:0], w_rgnt_a | w_rgnt_b};
      r_id_pipe  <= {r_id_pipe[RD_LATENCY-1:0],  w_rgnt_b};
      if (w_rgnt_a)      r_radd <= a_radd_in;
      else if (w_rgnt_b) r_radd <= b_radd_in;
    end
  end

  assign ram_ren_out  = r_vld_pipe[0];
  assign ram_radd_out = r_radd;

  // ---------------- response routing ----------------
  logic w_tag_v, w_tag_b, w_hit_a, w_hit_b;
  assign w_tag_v = r_vld_pipe[RD_LATENCY];
  assign w_tag_b = r_id_pipe[RD_LATENCY];
  assign w_hit_a = w_tag_v && ram_rval_in && !w_tag_b;
  assign w_hit_b = w_tag_v && ram_rval_in &&  w_tag_b;

  logic              r_a_rval, r_b_rval, r_err;
  logic [DATA_W-1:0] r_a_rdata, r_b_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_rval  <= 1'b0;
      r_b_rval  <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_err     <= 1'b0;
    end else begin
      r_a_rval <= w_hit_a;
      r_b_rval <= w_hit_b;
      if (w_hit_a) r_a_rdata <= ram_rdata_in;
      if (w_hit_b) r_b_rdata <= ram_rdata_in;
      // tag without data (dropped) or data without tag (ignored)
      if (w_tag_v != ram_rval_in) r_err <= 1'b1;
    end
  end

  assign a_rval_out  = r_a_rval;
  assign b_rval_out  = r_b_rval;
  assign a_rdata_out = r_a_rdata;
  assign b_rdata_out = r_b_rdata;
  assign err_out     = r_err;
endmodule

// File: tb/tb_parameter_ram_arbiter.sv
module tb_parameter_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] a_wdata_in = '0, b_wdata_in = '0, a_wmask_in = '0, b_wmask_in = '0;
  logic [AW-1:0] a_wadd_in = '0, b_wadd_in = '0, a_radd_in = '0, b_radd_in = '0;
  logic          a_wreq_in = 1'b0, b_wreq_in = 1'b0, a_rreq_in = 1'b0, b_rreq_in = 1'b0;
  logic          a_wack_out, b_wack_out, a_rack_out, b_rack_out;
  logic [DW-1:0] a_rdata_out, b_rdata_out;
  logic          a_rval_out, b_rval_out;
  logic [DW-1:0] ram_wdata_out, ram_wmask_out;
  logic [AW-1:0] ram_wadd_out, ram_radd_out;
  logic          ram_wval_out, ram_wen_out, ram_ren_out;
  logic [DW-1:0] ram_rdata_in;
  logic          ram_rval_in;
  logic          err_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parameter_ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .a_wdata_in(a_wdata_in), .a_wadd_in(a_wadd_in), .a_wmask_in(a_wmask_in),
    .a_wreq_in(a_wreq_in), .a_wack_out(a_wack_out),
    .b_wdata_in(b_wdata_in), .b_wadd_in(b_wadd_in), .b_wmask_in(b_wmask_in),
    .b_wreq_in(b_wreq_in), .b_wack_out(b_wack_out),
    .a_radd_in(a_radd_in), .a_rreq_in(a_rreq_in), .a_rack_out(a_rack_out),
    .b_radd_in(b_radd_in), .b_rreq_in(b_rreq_in), .b_rack_out(b_rack_out),
    .a_rdata_out(a_rdata_out), .a_rval_out(a_rval_out),
    .b_rdata_out(b_rdata_out), .b_rval_out(b_rval_out),
    .ram_wdata_out(ram_wdata_out), .ram_wadd_out(ram_wadd_out),
    .ram_wmask_out(ram_wmask_out), .ram_wval_out(ram_wval_out),
    .ram_wen_out(ram_wen_out), .ram_radd_out(ram_radd_out), .ram_ren_out(ram_ren_out),
    .ram_rdata_in(ram_rdata_in), .ram_rval_in(ram_rval_in), .err_out(err_out)
  );

  // Behavioural parameter_ram, read latency 1, masked write, read-before-write.
  logic [DW-1:0] mem [32] = '{default: '0};
  logic [DW-1:0] m_rdata = '0;
  logic          m_rval  = 1'b0;
  logic          inj     = 1'b0;

  always @(posedge clk) begin
    if (ram_wen_out && ram_wval_out)
      mem[ram_wadd_out] <= (mem[ram_wadd_out] & ~ram_wmask_out) | (ram_wdata_out & ram_wmask_out);
    m_rval <= ram_ren_out;
    if (ram_ren_out) m_rdata <= mem[ram_radd_out];
  end

  assign ram_rdata_in = m_rdata;
  assign ram_rval_in  = m_rval | inj;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drop_reqs();
    a_wreq_in = 0; b_wreq_in = 0; a_rreq_in = 0; b_rreq_in = 0;
  endtask

  task automatic do_reset();
    drop_reqs();
    rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  // A read of addr, optionally with a concurrent full-mask B write.
  // lat counts rising edges from acceptance (acceptance edge = 1) to a_rval.
  task automatic rd_a(input logic [AW-1:0] addr, input bit with_bw,
                      input logic [DW-1:0] bw_data,
                      output logic [DW-1:0] data, output int lat, output bit bseen);
    @(negedge clk);
    a_radd_in = addr; a_rreq_in = 1;
    if (with_bw) begin
      b_wadd_in = addr; b_wdata_in = bw_data; b_wmask_in = '1; b_wreq_in = 1;
    end
    #1;
    chk("rd_a_rack", a_rack_out, 1);
    if (with_bw) chk("rd_a_bwack", b_wack_out, 1);
    @(posedge clk);
    #1;
    a_rreq_in = 0; b_wreq_in = 0;
    lat = 0; data = '0; bseen = 0;
    for (int k = 1; k <= 8; k++) begin
      if (b_rval_out) bseen = 1;
      if (a_rval_out) begin
        lat = k; data = a_rdata_out;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct packed {
    logic wa, wb, ra, rb;
    logic ewa, ewb, era, erb;
  } vec_t;

  vec_t          tbl [10];
  logic [DW-1:0] rdat;
  int            lat;
  bit            bseen;
  int            who [8];
  logic [DW-1:0] dat [8];
  int            cyc [8];
  int            nr;
  bit            seen;

  initial begin
    // wreqA wreqB rreqA rreqB | wackA wackB rackA rackB ; both arbiters start favouring A
    tbl[0] = '{1,0,0,1, 1,0,0,1};
    tbl[1] = '{0,1,0,0, 0,1,0,0};
    tbl[2] = '{1,1,1,1, 1,0,1,0};  // wpri->B rpri->B
    tbl[3] = '{1,1,1,0, 0,1,1,0};  // wpri->A, rpri stays B
    tbl[4] = '{1,1,1,1, 1,0,0,1};  // wpri->B rpri->A
    tbl[5] = '{1,0,1,1, 1,0,1,0};  // wpri stays B, rpri->B
    tbl[6] = '{1,1,0,0, 0,1,0,0};  // wpri->A
    tbl[7] = '{0,0,1,1, 0,0,0,1};  // rpri->A
    tbl[8] = '{1,1,1,1, 1,0,1,0};
    tbl[9] = '{0,0,0,0, 0,0,0,0};

    // ---- reset state (requests held high to show acks are gated) ----
    a_wreq_in = 1; b_rreq_in = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wack_a", a_wack_out, 0);
    chk("rst_rack_b", b_rack_out, 0);
    chk("rst_wen",    ram_wen_out, 0);
    chk("rst_wval",   ram_wval_out, 0);
    chk("rst_ren",    ram_ren_out, 0);
    chk("rst_wdata",  ram_wdata_out, 0);
    chk("rst_radd",   ram_radd_out, 0);
    chk("rst_arval",  a_rval_out, 0);
    chk("rst_brval",  b_rval_out, 0);
    chk("rst_err",    err_out, 0);
    drop_reqs();
    @(negedge clk);
    rst = 1;

    // ---- table: arbitration on both paths, mask 0 so memory is untouched ----
    a_wadd_in = 1; b_wadd_in = 2; a_radd_in = 3; b_radd_in = 4;
    a_wmask_in = '0; b_wmask_in = '0;
    for (int i = 0; i < 10; i++) begin
      a_wreq_in = tbl[i].wa; b_wreq_in = tbl[i].wb;
      a_rreq_in = tbl[i].ra; b_rreq_in = tbl[i].rb;
      #1;
      chk($sformatf("tbl%0d_wack_a", i), a_wack_out, tbl[i].ewa);
      chk($sformatf("tbl%0d_wack_b", i), b_wack_out, tbl[i].ewb);
      chk($sformatf("tbl%0d_rack_a", i), a_rack_out, tbl[i].era);
      chk($sformatf("tbl%0d_rack_b", i), b_rack_out, tbl[i].erb);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_wen", i), ram_wen_out, tbl[i].ewa | tbl[i].ewb);
      chk($sformatf("tbl%0d_ren", i), ram_ren_out, tbl[i].era | tbl[i].erb);
      if (tbl[i].ewa) chk($sformatf("tbl%0d_wadd", i), ram_wadd_out, 1);
      if (tbl[i].ewb) chk($sformatf("tbl%0d_wadd", i), ram_wadd_out, 2);
      if (tbl[i].era) chk($sformatf("tbl%0d_radd", i), ram_radd_out, 3);
      if (tbl[i].erb) chk($sformatf("tbl%0d_radd", i), ram_radd_out, 4);
      @(negedge clk);
    end
    drop_reqs();
    repeat (4) @(posedge clk);
    #1;
    chk("tbl_err", err_out, 0);

    // ---- single write then read ----
    @(negedge clk);
    a_wadd_in = 3; a_wdata_in = 32'hDEADBEEF; a_wmask_in = '1; a_wreq_in = 1;
    #1;
    chk("sw_wack_a", a_wack_out, 1);
    chk("sw_wack_b", b_wack_out, 0);
    @(posedge clk);
    #1;
    a_wreq_in = 0;
    chk("sw_wen",   ram_wen_out, 1);
    chk("sw_wval",  ram_wval_out, 1);
    chk("sw_wadd",  ram_wadd_out, 3);
    chk("sw_wdata", ram_wdata_out, 32'hDEADBEEF);
    chk("sw_wmask", ram_wmask_out, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    chk("sw_wen_off", ram_wen_out, 0);
    chk("sw_wadd_hold", ram_wadd_out, 3);
    rd_a(3, 0, '0, rdat, lat, bseen);
    chk("sr_lat", lat, 3);
    chk("sr_data", rdat, 32'hDEADBEEF);
    chk("sr_no_b", bseen, 0);
    @(posedge clk);
    #1;
    chk("sr_pulse", a_rval_out, 0);
    chk("sr_hold", a_rdata_out, 32'hDEADBEEF);

    // ---- write contention from a fresh reset ----
    do_reset();
    a_wadd_in = 1; a_wdata_in = 32'h11; a_wmask_in = '1; a_wreq_in = 1;
    b_wadd_in = 2; b_wdata_in = 32'h22; b_wmask_in = '1; b_wreq_in = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("wc%0d_wack_a", k), a_wack_out, (k % 2) == 0);
      chk($sformatf("wc%0d_wack_b", k), b_wack_out, (k % 2) == 1);
      @(posedge clk);
      #1;
      chk($sformatf("wc%0d_wen", k), ram_wen_out, 1);
      chk($sformatf("wc%0d_wadd", k), ram_wadd_out, ((k % 2) == 0) ? 1 : 2);
      if (k == 3) drop_reqs();
      @(negedge clk);
    end

    // ---- read contention with routing ----
    do_reset();
    a_radd_in = 1; a_rreq_in = 1;
    b_radd_in = 2; b_rreq_in = 1;
    nr = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 4) drop_reqs();
      if (a_rval_out && nr < 8) begin who[nr] = 0; dat[nr] = a_rdata_out; cyc[nr] = c; nr++; end
      if (b_rval_out && nr < 8) begin who[nr] = 1; dat[nr] = b_rdata_out; cyc[nr] = c; nr++; end
    end
    chk("rc_count", nr, 4);
    if (nr >= 4) begin
      chk("rc_first_cyc", cyc[0], 3);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rc%0d_who", k), who[k], k % 2);
        chk($sformatf("rc%0d_data", k), dat[k], ((k % 2) == 0) ? 32'h11 : 32'h22);
        chk($sformatf("rc%0d_cyc", k), cyc[k], 3 + k);
      end
    end
    chk("rc_err", err_out, 0);

    // ---- concurrent read/write to the same address ----
    rd_a(5, 1, 32'h55, rdat, lat, bseen);
    chk("cc_old_data", rdat, 32'h0);
    chk("cc_lat", lat, 3);
    rd_a(5, 0, '0, rdat, lat, bseen);
    chk("cc_new_data", rdat, 32'h55);

    // ---- reset mid-read ----
    @(negedge clk);
    a_radd_in = 3; a_rreq_in = 1;
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("mr_ren",   ram_ren_out, 0);
    chk("mr_wen",   ram_wen_out, 0);
    chk("mr_radd",  ram_radd_out, 0);
    chk("mr_wadd",  ram_wadd_out, 0);
    chk("mr_rack",  a_rack_out, 0);
    a_rreq_in = 0;
    @(negedge clk);
    rst = 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (a_rval_out) seen = 1;
    end
    chk("mr_no_rval", seen, 0);
    chk("mr_err", err_out, 0);

    // ---- fault injection: rval with nothing outstanding ----
    @(negedge clk);
    inj = 1;
    @(posedge clk);
    #1;
    inj = 0;
    chk("fi_err_set", err_out, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("fi_err_sticky", err_out, 1);
    do_reset();
    #1;
    chk("fi_err_clr", err_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parameter_ram_arbiter.md
Name: parameter_ram_arbiter

Overview:
Shares the single write port and single read port of parameter_ram between two requesters: A (host register bus) and B (on-chip sequencer/loader). Write and read paths are arbitrated independently, each with round-robin priority. Commands to the RAM are registered. Read responses are routed back to the issuing requester using a tag pipeline matched to the RAM read latency. Sits directly in front of parameter_ram and drives all of its request inputs.

Parameters:
DATA_W, 32, data and mask width
ADDR_W, 5, RAM address width
RD_LATENCY, 1, cycles from ram_ren_out high to ram_rval_in high (1..4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
a_wdata_in / b_wdata_in  in  DATA_W  write data
a_wadd_in / b_wadd_in  in  ADDR_W  write address
a_wmask_in / b_wmask_in  in  DATA_W  write bit mask
a_wreq_in / b_wreq_in  in  1  write request, held until acked
a_wack_out / b_wack_out  out  1  write accepted this cycle (combinational)
a_radd_in / b_radd_in  in  ADDR_W  read address
a_rreq_in / b_rreq_in  in  1  read request, held until acked
a_rack_out / b_rack_out  out  1  read accepted this cycle (combinational)
a_rdata_out / b_rdata_out  out  DATA_W  read response data
a_rval_out / b_rval_out  out  1  read response valid, one-cycle pulse
ram_wdata_out  out  DATA_W  to parameter_ram wdata_in
ram_wadd_out  out  ADDR_W  to wadd_in
ram_wmask_out  out  DATA_W  to wmask_in
ram_wval_out  out  1  to wval_in
ram_wen_out  out  1  to wen_in
ram_radd_out  out  ADDR_W  to radd_in
ram_ren_out  out  1  to ren_in
ram_rdata_in  in  DATA_W  from rdata_out
ram_rval_in  in  1  from rval_out
err_out  out  1  sticky error: unexpected or missing rval

Behaviour:
- Reset (rst=0, async): all registered outputs 0. Both round-robin pointers favour A. Tag pipeline cleared. err_out cleared. Acks are 0 while rst=0.
- Write arbitration, per cycle:
  - Only one requester asserting wreq: that requester is granted.
  - Both asserting: the requester holding priority is granted; priority then passes to the other.
  - Priority is unchanged when there is no contention.
  - wack = grant. A transfer occurs on req && ack.
- Write issue: on the cycle after acceptance, ram_wval_out = ram_wen_out = 1, carrying the registered wdata, wadd and wmask. Otherwise both are 0 and the data, address and mask registers hold their last values. Sustained throughput is one write per cycle.
- Read arbitration: identical rules, using a separate pointer.
- Read issue: on the cycle after acceptance, ram_ren_out = 1 with the registered radd. At the same time a tag is pushed into a shift pipeline of depth RD_LATENCY: valid=1, id = 0 for A, 1 for B.
- Read response, when the tag at stage RD_LATENCY is valid:
  - If ram_rval_in = 1: on the next cycle the tagged requester gets rval_out=1 and rdata_out = captured ram_rdata_in. The other requester's rval stays 0.
  - If ram_rval_in = 0: err_out is set and the response is dropped.
- ram_rval_in = 1 with no valid tag at stage RD_LATENCY: err_out is set and the data is ignored.
- Read latency: acceptance to rval_out = RD_LATENCY + 2 cycles (3 at default). rdata_out holds its value between pulses.
- Simultaneous events:
  - A read and a write are accepted independently in the same cycle, from the same or different requesters.
  - When a read and a write to the same address issue in the same cycle, the read returns the pre-write data. Ordering across paths is not enforced.
- Requests deasserted before ack are simply not served. No error is raised.
- Reset mid-operation: in-flight tags are discarded and no rval_out is produced for them. err_out is cleared.

Test Plan:
- Single write then read: A writes wadd=3, wdata=0xDEADBEEF, mask=0xFFFFFFFF, acked the same cycle. The RAM sees wen/wval the next cycle. A reads radd=3 -> a_rval_out=1 three cycles after rack with a_rdata_out=0xDEADBEEF; b_rval_out stays 0.
- Write contention: A and B both hold wreq for 4 cycles, writing addr 1 and addr 2 -> acks alternate A,B,A,B starting with A. RAM writes alternate accordingly and priority flips each granted cycle.
- Read contention with routing: A reads addr 1 (contents 0x11) and B reads addr 2 (0x22), both continuously -> responses alternate a_rval 0x11 and b_rval 0x22 back-to-back with no dropped cycles.
- Concurrent read/write: in the same cycle B writes addr 5 = 0x55 and A reads addr 5 (old value 0x0) -> A receives 0x0. A's next read of addr 5 returns 0x55.
- Fault injection: force ram_rval_in=1 with no read outstanding -> err_out=1 and stays 1 until rst=0.
- Reset mid-read: A's read is accepted and rst is pulsed low for 1 cycle before the response -> no a_rval_out for that read, err_out=0, and all RAM command outputs are 0 during reset.
